ecc_stream_decoder: RTL and testbench
=====================================

ECC_STREAM_DECODER -- requirements
Module: ecc_stream_decoder

Interface
REQ-001 Parameter: CNT_W, default 16, width of the saturating event counters.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  upstream codeword valid.
REQ-005 in_ready  output  1  decoder can accept a codeword this cycle.
REQ-006 in_code  input  13  SECDED codeword: bit0 = overall parity; bits 1..12 = Hamming positions 1..12.
REQ-007 out_valid  output  1  decoded result valid.
REQ-008 out_ready  input  1  downstream accepts the result.
REQ-009 out_data  output  8  corrected data, bits 7..0 taken from positions 12,11,10,9,7,6,5,3.
REQ-010 out_corr  output  1  single-bit error corrected.
REQ-011 out_uncorr  output  1  uncorrectable error detected.
REQ-012 out_syndrome  output  4  raw Hamming syndrome for this word.
REQ-013 cnt_clr  input  1  synchronous clear of both counters.
REQ-014 cnt_corr  output  CNT_W  count of delivered words with out_corr=1.
REQ-015 cnt_uncorr  output  CNT_W  count of delivered words with out_uncorr=1.

Function
REQ-016 Hamming parity bits sit at positions 1,2,4,8; syndrome bit k SHALL be the XOR of all positions whose index has bit k set.
REQ-017 Overall parity error p SHALL be the XOR of all 13 in_code bits.
REQ-018 Classification: s=0,p=0 clean; p=1 and s<=12 corrected, flip position s (s=0 flips bit0 only); p=1 and s>=13 uncorrectable; s!=0,p=0 uncorrectable (double error).
REQ-019 When uncorrectable, out_data SHALL be the uncorrected data bits.
REQ-020 Two-stage pipeline: stage 1 registers in_code with its syndrome and p; stage 2 registers the corrected data and flags.
REQ-021 Latency SHALL be exactly 2 cycles from input handshake to out_valid with out_ready held high; throughput 1 word/cycle.
REQ-022 Handshake on valid&ready; a stage advances when it is empty or the next stage advances; in_ready SHALL be combinational from stage state and out_ready only, never from in_valid.
REQ-023 While out_valid=1 and out_ready=0, all outputs SHALL hold stable; no word is dropped or duplicated.
REQ-024 Counters SHALL increment by 1 on each output handshake carrying the matching flag, and saturate at all-ones.
REQ-025 cnt_clr SHALL zero both counters next cycle and take priority over a same-cycle increment.

Reset
REQ-026 Reset SHALL clear both stage valid bits, out_valid=0, out_data=0, out_corr=0, out_uncorr=0, out_syndrome=0, cnt_corr=0, cnt_uncorr=0.
REQ-027 in_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-028 Reset mid-operation SHALL discard all in-flight words without counting them.

Structure
REQ-029 Shared package holds codeword/data widths, parity-position and data-position constants, and the syndrome-classification enum (CLEAN, CORR, UNCORR).
REQ-030 One sub-module, ecc_syndrome_calc (combinational: in_code -> syndrome, p), shared with the matching encoder's self-check.

Verification
REQ-031 in_code=0x144E, out_ready=1 -> 2 cycles later out_data=0xA5, out_corr=0, out_uncorr=0, out_syndrome=0.
REQ-032 in_code=0x140E (bit 6 flipped) -> out_data=0xA5, out_corr=1, out_syndrome=6, cnt_corr=1.
REQ-033 in_code=0x144F (bit0 flipped) -> out_data=0xA5, out_corr=1, out_syndrome=0.
REQ-034 in_code=0x1466 (bits 3,5 flipped) -> out_uncorr=1, out_syndrome=6, cnt_uncorr=1.
REQ-035 Stream 8 words with out_ready low for cycles 3-6 -> in_ready drops once both stages are full, outputs stable while stalled, all 8 delivered in order.
REQ-036 CNT_W=2, 5 corrected words then cnt_clr together with a 6th corrected handshake -> cnt_corr saturates at 3, then reads 0.

Source files
------------

// File: rtl/ecc_stream_decoder_pkg.sv
// Shared SECDED(13,8) constants, stage record and classification helpers.
// Positions 1..12 follow Hamming numbering; bit 0 is the overall parity bit.
package ecc_stream_decoder_pkg;

  localparam int CODE_W  = 13;
  localparam int DATA_W  = 8;
  localparam int SYN_W   = 4;
  localparam int MAX_POS = 12;

  localparam logic [CODE_W-1:0] PARITY_POS_MASK = 13'h0116;  // positions 1,2,4,8
  localparam logic [CODE_W-1:0] DATA_POS_MASK   = 13'h1EE8;  // positions 3,5,6,7,9,10,11,12

  // Entry k selects every position whose index has bit k set.
  localparam logic [SYN_W-1:0][CODE_W-1:0] SYN_MASK = {13'h1F00, 13'h10F0, 13'h0CCC, 13'h0AAA};

  typedef enum logic [1:0] {
    CLEAN,
    CORR,
    UNCORR
  } syn_class_e;

  typedef struct packed {
    logic [CODE_W-1:0] code;
    logic [SYN_W-1:0]  syn;
    logic              p;
  } stage1_t;

  // Data bit 0 comes from the lowest data position, bit 7 from position 12.
  function automatic logic [DATA_W-1:0] extract_data(input logic [CODE_W-1:0] code);
    logic [DATA_W-1:0] d;
    int j;
    d = '0;
    j = 0;
    for (int i = 0; i < CODE_W; i++) begin
      if (DATA_POS_MASK[i]) begin
        d[j] = code[i];
        j++;
      end
    end
    return d;
  endfunction

  function automatic syn_class_e classify(input logic [SYN_W-1:0] syn, input logic p);
    if (!p) begin
      return (syn == '0) ? CLEAN : UNCORR;
    end
    return (int'(syn) <= MAX_POS) ? CORR : UNCORR;
  endfunction

endpackage

// File: rtl/ecc_syndrome_calc.sv
// Combinational Hamming syndrome and overall parity of a 13-bit SECDED codeword.
module ecc_syndrome_calc
  import ecc_stream_decoder_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output logic [SYN_W-1:0]  syndrome,
  output logic              parity_err
);

  always_comb begin
    syndrome = '0;
    for (int k = 0; k < SYN_W; k++) begin
      syndrome[k] = ^(code & SYN_MASK[k]);
    end
    parity_err = ^code;
  end

endmodule

// File: rtl/ecc_stream_decoder.sv
// Two-stage valid/ready SECDED decoder: stage 1 holds code+syndrome, stage 2 the result.
// Latency 2 cycles, 1 word/cycle; in_ready depends only on stage occupancy and out_ready.
module ecc_stream_decoder
  import ecc_stream_decoder_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_corr,
  output logic              out_uncorr,
  output logic [SYN_W-1:0]  out_syndrome,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  cnt_corr,
  output logic [CNT_W-1:0]  cnt_uncorr
);

  logic              s1_vld;
  stage1_t           s1;
  logic [SYN_W-1:0]  syn_c;
  logic              p_c;
  logic              out_adv;
  logic              s1_adv;
  logic              in_fire;
  logic              out_fire;
  syn_class_e        cls;
  logic [CODE_W-1:0] fixed;

  ecc_syndrome_calc u_syn (
    .code       (in_code),
    .syndrome   (syn_c),
    .parity_err (p_c)
  );

  assign out_adv  = !out_valid || out_ready;
  assign s1_adv   = !s1_vld || out_adv;
  assign in_ready = s1_adv;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld <= 1'b0;
      s1     <= '0;
    end else if (s1_adv) begin
      s1_vld <= in_valid;
      if (in_fire) begin
        s1 <= '{code: in_code, syn: syn_c, p: p_c};
      end
    end
  end

  // A syndrome of 0 with p=1 flips only the overall parity bit, leaving data intact.
  always_comb begin
    cls   = classify(s1.syn, s1.p);
    fixed = s1.code;
    if (cls == CORR) begin
      fixed = s1.code ^ ({{(CODE_W-1){1'b0}}, 1'b1} << s1.syn);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_corr     <= 1'b0;
      out_uncorr   <= 1'b0;
      out_syndrome <= '0;
    end else if (out_adv) begin
      out_valid <= s1_vld;
      if (s1_vld) begin
        out_data     <= extract_data(fixed);
        out_corr     <= (cls == CORR);
        out_uncorr   <= (cls == UNCORR);
        out_syndrome <= s1.syn;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      cnt_corr   <= '0;
      cnt_uncorr <= '0;
    end else if (out_fire) begin
      if (out_corr && (cnt_corr != '1)) begin
        cnt_corr <= cnt_corr + 1'b1;
      end
      if (out_uncorr && (cnt_uncorr != '1)) begin
        cnt_uncorr <= cnt_uncorr + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ecc_stream_decoder.sv
// Directed + scoreboard bench for ecc_stream_decoder (default and CNT_W=2 instances).
module tb_ecc_stream_decoder;

  typedef struct packed {
    logic [7:0] data;
    logic       corr;
    logic       uncorr;
    logic [3:0] syn;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [12:0] in_code;
  logic        out_ready;
  logic        cnt_clr;

  logic        in_ready, out_valid, out_corr, out_uncorr;
  logic [7:0]  out_data;
  logic [3:0]  out_syndrome;
  logic [15:0] cnt_corr, cnt_uncorr;

  logic        in_ready2, out_valid2, out_corr2, out_uncorr2;
  logic [7:0]  out_data2;
  logic [3:0]  out_syndrome2;
  logic [1:0]  cnt_corr2, cnt_uncorr2;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   m_corr = 0, m_unc = 0, m_corr2 = 0, m_unc2 = 0;
  int   n_pop = 0;
  logic saw_full = 1'b0;
  logic prev_stall = 1'b0;
  exp_t prev_out;

  always #5 clk = ~clk;

  ecc_stream_decoder #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_corr(out_corr),
    .out_uncorr(out_uncorr), .out_syndrome(out_syndrome), .cnt_clr(cnt_clr),
    .cnt_corr(cnt_corr), .cnt_uncorr(cnt_uncorr)
  );

  ecc_stream_decoder #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .in_code(in_code),
    .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2), .out_corr(out_corr2),
    .out_uncorr(out_uncorr2), .out_syndrome(out_syndrome2), .cnt_clr(cnt_clr),
    .cnt_corr(cnt_corr2), .cnt_uncorr(cnt_uncorr2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] ref_syn(input logic [12:0] c);
    logic [3:0] s;
    s = '0;
    for (int i = 1; i <= 12; i++)
      for (int k = 0; k < 4; k++)
        if (((i >> k) & 1) == 1) s[k] = s[k] ^ c[i];
    return s;
  endfunction

  function automatic logic [12:0] encode(input logic [7:0] d);
    int dp[8] = '{3, 5, 6, 7, 9, 10, 11, 12};
    logic [12:0] c;
    logic [3:0]  s;
    c = '0;
    for (int j = 0; j < 8; j++) c[dp[j]] = d[j];
    s = ref_syn(c);
    c[1] = s[0]; c[2] = s[1]; c[4] = s[2]; c[8] = s[3];
    c[0] = ^c[12:1];
    return c;
  endfunction

  function automatic exp_t ref_decode(input logic [12:0] c);
    exp_t e;
    logic [12:0] cc;
    logic [3:0]  s;
    logic        p;
    s = ref_syn(c);
    p = ^c;
    cc = c;
    e = '0;
    e.syn = s;
    if (p) begin
      if (s <= 4'd12) begin
        e.corr = 1'b1;
        cc[s] = ~cc[s];
      end else e.uncorr = 1'b1;
    end else if (s != 4'd0) e.uncorr = 1'b1;
    e.data = {cc[12], cc[11], cc[10], cc[9], cc[7], cc[6], cc[5], cc[3]};
    return e;
  endfunction

  // Monitor: scoreboard pop, stall stability, and counter model (checked before update).
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      m_corr = 0; m_unc = 0; m_corr2 = 0; m_unc2 = 0;
      prev_stall = 1'b0;
    end else begin
      check("cnt_corr", cnt_corr, m_corr);
      check("cnt_uncorr", cnt_uncorr, m_unc);
      check("cnt_corr_w2", cnt_corr2, m_corr2);
      check("cnt_uncorr_w2", cnt_uncorr2, m_unc2);
      check("in_ready_w2", in_ready2, in_ready);
      if (prev_stall) begin
        check("stall_valid", out_valid, 1);
        check("stall_outputs", {out_data, out_corr, out_uncorr, out_syndrome}, prev_out);
      end
      if (out_valid && !out_ready && !in_ready) saw_full = 1'b1;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_output", 1, 0);
        end else begin
          e = sb.pop_front();
          n_pop++;
          check("out_data", out_data, e.data);
          check("out_corr", out_corr, e.corr);
          check("out_uncorr", out_uncorr, e.uncorr);
          check("out_syndrome", out_syndrome, e.syn);
          check("out_w2", {out_valid2, out_data2, out_corr2, out_uncorr2, out_syndrome2}, {1'b1, e});
          if (cnt_clr) begin
            m_corr = 0; m_unc = 0; m_corr2 = 0; m_unc2 = 0;
          end else begin
            if (e.corr)   begin if (m_corr < 65535) m_corr++;  if (m_corr2 < 3) m_corr2++; end
            if (e.uncorr) begin if (m_unc < 65535)  m_unc++;   if (m_unc2 < 3)  m_unc2++;  end
          end
        end
      end else if (cnt_clr) begin
        m_corr = 0; m_unc = 0; m_corr2 = 0; m_unc2 = 0;
      end
      prev_stall = out_valid && !out_ready;
      prev_out = {out_data, out_corr, out_uncorr, out_syndrome};
    end
  end

  // All stimulus changes land 1ns after a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [12:0] c, input exp_t e);
    logic hs;
    int guard;
    in_valid = 1'b1;
    in_code  = c;
    guard = 0;
    hs = 1'b0;
    while (!hs) begin
      @(negedge clk);
      hs = in_ready;
      step();
      guard++;
      if (!hs && guard > 200) begin
        check("send_timeout", 0, 1);
        break;
      end
    end
    if (hs) sb.push_back(e);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while ((sb.size() != 0 || out_valid) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) check("drain_timeout", 0, 1);
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic [12:0] c;
    rst = 1'b1; in_valid = 1'b0; in_code = '0; out_ready = 1'b1; cnt_clr = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_outputs", {out_data, out_corr, out_uncorr, out_syndrome}, 0);
    check("rst_counters", {cnt_corr, cnt_uncorr}, 0);
    check("rst_in_ready", in_ready, 1);
    step();

    // Clean word with exact 2-cycle latency.
    send(13'h144E, '{8'hA5, 1'b0, 1'b0, 4'd0});
    @(negedge clk);
    check("latency_c1", out_valid, 0);
    @(negedge clk);
    check("latency_c2", out_valid, 1);
    step();
    drain();

    send(13'h140E, '{8'hA5, 1'b1, 1'b0, 4'd6});
    drain();
    check("cnt_corr_after_1", cnt_corr, 1);
    send(13'h144F, '{8'hA5, 1'b1, 1'b0, 4'd0});
    send(13'h1466, '{8'hA6, 1'b0, 1'b1, 4'd6});
    drain();
    check("cnt_uncorr_after_1", cnt_uncorr, 1);
    send(13'h155C, '{8'hA5, 1'b0, 1'b1, 4'd13});
    send(13'h044E, '{8'hA5, 1'b1, 1'b0, 4'd12});
    drain();

    // Eight-word stream with a 4-cycle downstream stall.
    base = n_pop;
    saw_full = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          c = encode(8'(i * 37 + 1));
          if (i % 3 == 1) c = c ^ (13'h1 << (i + 1));
          if (i % 3 == 2) c = c ^ (13'h3 << i);
          send(c, ref_decode(c));
        end
      end
      begin
        repeat (3) step();
        out_ready = 1'b0;
        repeat (4) step();
        out_ready = 1'b1;
      end
    join
    drain();
    check("stream_backpressure", saw_full, 1);
    check("stream_count", n_pop - base, 8);

    // Random words with random single/double flips and random backpressure.
    fork
      begin
        for (int i = 0; i < 24; i++) begin
          c = encode(8'($urandom));
          case ($urandom_range(0, 2))
            1: c = c ^ (13'h1 << $urandom_range(0, 12));
            2: c = c ^ (13'h1 << $urandom_range(0, 6)) ^ (13'h1 << $urandom_range(7, 12));
            default: ;
          endcase
          send(c, ref_decode(c));
        end
      end
      begin
        repeat (40) begin
          step();
          out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Saturation of the 2-bit counters, then clear on a counted handshake.
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    @(negedge clk);
    check("clr_cnt_corr_w2", cnt_corr2, 0);
    step();
    repeat (5) send(13'h140E, '{8'hA5, 1'b1, 1'b0, 4'd6});
    drain();
    check("sat_cnt_corr_w2", cnt_corr2, 3);
    check("sat_cnt_corr_w16", cnt_corr, 5);
    send(13'h140E, '{8'hA5, 1'b1, 1'b0, 4'd6});
    step();
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    @(negedge clk);
    check("clr_prio_w2", cnt_corr2, 0);
    check("clr_prio_w16", cnt_corr, 0);
    step();
    drain();

    // Reset while two words are in flight: nothing delivered, nothing counted.
    send(13'h140E, '{8'hA5, 1'b1, 1'b0, 4'd6});
    send(13'h1466, '{8'hA6, 1'b0, 1'b1, 4'd6});
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    check("rst_mid_in_ready", in_ready, 1);
    repeat (4) begin
      check("rst_mid_no_output", out_valid, 0);
      check("rst_mid_counters", {cnt_corr, cnt_uncorr}, 0);
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
